// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam int DEF_LATENCY    = 3;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      state, state_n;
  owner_t      owner;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  lat_cnt;
  logic [2:0]  starve_cnt;
  logic        grant_data, grant_fetch, fetch_abort, starved;

  assign starved = (starve_cnt == 3'(STARVE_MAX));

  // Data normally wins; fetch only takes priority once it has been starved.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (d_req && !(if_req && starved))
      grant_data = 1'b1;
    else if (if_req)
      grant_fetch = 1'b1;
  end

  // A fetch is dropped if the requester withdraws or redirects mid-access.
  assign fetch_abort = (owner == OWN_FETCH) && (!if_req || (if_addr != addr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_ack    = 1'b0;
    if_rdata  = '0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        if (grant_data || grant_fetch)
          state_n = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (fetch_abort)
          state_n = IDLE;
        else if (lat_cnt == 3'(LATENCY - 1))
          state_n = RESP;
      end
      RESP: begin
        busy    = 1'b1;
        state_n = IDLE;
        if (owner == OWN_FETCH) begin
          if_ack   = 1'b1;
          if_rdata = mem_rdata;
        end else begin
          d_ack   = 1'b1;
          d_rdata = we_q ? 32'h0 : mem_rdata;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      lat_cnt <= '0;
      if (grant_data) begin
        owner   <= OWN_DATA;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        be_q    <= d_be;
        we_q    <= d_we;
        if (!if_req)
          starve_cnt <= '0;
        else if (!starved)
          starve_cnt <= starve_cnt + 3'd1;
      end else if (grant_fetch) begin
        owner      <= OWN_FETCH;
        addr_q     <= if_addr;
        wdata_q    <= '0;
        be_q       <= 4'hF;
        we_q       <= 1'b0;
        starve_cnt <= '0;
      end
    end else if (state == ACCESS) begin
      lat_cnt <= lat_cnt + 3'd1;
    end
  end

endmodule
